// File: rtl/hba_pkg.sv
// Shared definitions for the HBA command master: FSM encoding, default widths
// and the register-field address increment.
package hba_pkg;

   localparam int HBA_DBUS_WIDTH        = 8;
   localparam int HBA_PERIPH_ADDR_WIDTH = 4;
   localparam int HBA_REG_ADDR_WIDTH    = 8;
   localparam int HBA_TIMEOUT_CYCLES    = 64;
   localparam int HBA_BEATS_WIDTH       = 5;   // holds 1..16 beats

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WDATA = 3'd1,
      ST_XFER  = 3'd2,
      ST_GAP   = 3'd3,
      ST_RSP   = 3'd4,
      ST_DRAIN = 3'd5
   } hba_state_e;

   // Increment only the low reg_w bits; the peripheral field above is untouched.
   function automatic logic [31:0] hba_addr_inc(input logic [31:0] addr, input int reg_w);
      logic [31:0] mask;
      mask = (32'd1 << reg_w) - 32'd1;
      return (addr & ~mask) | ((addr + 32'd1) & mask);
   endfunction

endpackage

// File: rtl/hba_timeout_ctr.sv
// Clear/enable cycle counter that stops at TERMINAL-1 and flags it, so the
// owner sees tc high during the TERMINAL-th enabled cycle.
module hba_timeout_ctr #(
   parameter int TERMINAL = 64
) (
   input  logic hba_clk,
   input  logic hba_reset,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int CW = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;

   logic [CW-1:0] cnt;

   assign tc = (cnt == CW'(TERMINAL - 1));

   always_ff @(posedge hba_clk) begin
      if (hba_reset || clr)
         cnt <= '0;
      else if (en && !tc)
         cnt <= cnt + CW'(1);
   end

endmodule

// File: rtl/hba_cmd_master.sv
// HBA bus initiator: turns upstream register-access commands into HBA
// read/write transfers, with bursts, auto-increment and an ack timeout.
module hba_cmd_master
   import hba_pkg::*;
#(
   parameter int DBUS_WIDTH        = HBA_DBUS_WIDTH,
   parameter int PERIPH_ADDR_WIDTH = HBA_PERIPH_ADDR_WIDTH,
   parameter int REG_ADDR_WIDTH    = HBA_REG_ADDR_WIDTH,
   parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
   parameter int TIMEOUT_CYCLES    = HBA_TIMEOUT_CYCLES
) (
   input  logic                  hba_clk,
   input  logic                  hba_reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_rnw,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [3:0]            cmd_count,
   input  logic                  wdata_valid,
   output logic                  wdata_ready,
   input  logic [DBUS_WIDTH-1:0] wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DBUS_WIDTH-1:0] rsp_data,
   output logic                  rsp_err,
   output logic                  hba_select,
   output logic                  hba_rnw,
   output logic [ADDR_WIDTH-1:0] hba_abus,
   output logic [DBUS_WIDTH-1:0] hba_dbus,
   input  logic                  hba_xferack,
   input  logic [DBUS_WIDTH-1:0] hba_dbus_slave
);

   hba_state_e                 state, state_n;
   logic [HBA_BEATS_WIDTH-1:0] beats;
   logic                       cmd_acc, wd_acc, rsp_acc;
   logic                       ack_hit, tmo_hit, tc, ctr_clr, ctr_en;
   logic                       more_beats;
   logic [ADDR_WIDTH-1:0]      abus_inc;

   assign cmd_acc    = cmd_valid & cmd_ready;
   assign wd_acc     = wdata_valid & wdata_ready;
   assign rsp_acc    = rsp_valid & rsp_ready;
   assign ack_hit    = (state == ST_XFER) & hba_xferack;
   // ack wins when it lands on the terminal cycle
   assign tmo_hit    = (state == ST_XFER) & ~hba_xferack & tc;
   assign more_beats = (beats != '0);
   assign abus_inc   = ADDR_WIDTH'(hba_addr_inc(32'(hba_abus), REG_ADDR_WIDTH));

   assign ctr_clr = (state_n == ST_XFER) && (state != ST_XFER);
   assign ctr_en  = (state == ST_XFER);

   hba_timeout_ctr #(
      .TERMINAL (TIMEOUT_CYCLES)
   ) u_tmo (
      .hba_clk   (hba_clk),
      .hba_reset (hba_reset),
      .clr       (ctr_clr),
      .en        (ctr_en),
      .tc        (tc)
   );

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE:
            if (cmd_acc) state_n = cmd_rnw ? ST_XFER : ST_WDATA;
         ST_WDATA:
            if (wd_acc) state_n = ST_XFER;
         ST_XFER:
            if (ack_hit)      state_n = ST_GAP;
            else if (tmo_hit) state_n = ST_RSP;
         ST_GAP:
            if (hba_rnw || !more_beats) state_n = ST_RSP;
            else                        state_n = ST_WDATA;
         ST_RSP:
            if (rsp_acc) begin
               if (rsp_err)
                  state_n = (!hba_rnw && more_beats) ? ST_DRAIN : ST_IDLE;
               else if (hba_rnw && more_beats)
                  state_n = ST_XFER;
               else
                  state_n = ST_IDLE;
            end
         ST_DRAIN:
            if (!more_beats || (wd_acc && beats == HBA_BEATS_WIDTH'(1))) state_n = ST_IDLE;
         default:
            state_n = ST_IDLE;
      endcase
   end

   // Handshake and bus outputs are registered copies of the next-state decode.
   always_ff @(posedge hba_clk) begin
      if (hba_reset) begin
         state       <= ST_IDLE;
         beats       <= '0;
         cmd_ready   <= 1'b0;
         wdata_ready <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         rsp_err     <= 1'b0;
         hba_select  <= 1'b0;
         hba_rnw     <= 1'b0;
         hba_abus    <= '0;
         hba_dbus    <= '0;
      end else begin
         state       <= state_n;
         cmd_ready   <= (state_n == ST_IDLE);
         wdata_ready <= (state_n == ST_WDATA) || (state_n == ST_DRAIN);
         rsp_valid   <= (state_n == ST_RSP);
         hba_select  <= (state_n == ST_XFER);
         case (state)
            ST_IDLE:
               if (cmd_acc) begin
                  hba_rnw  <= cmd_rnw;
                  hba_abus <= cmd_addr;
                  beats    <= {1'b0, cmd_count} + HBA_BEATS_WIDTH'(1);
               end
            ST_WDATA:
               if (wd_acc) hba_dbus <= wdata;
            ST_XFER:
               if (ack_hit) begin
                  beats    <= beats - HBA_BEATS_WIDTH'(1);
                  rsp_data <= hba_rnw ? hba_dbus_slave : '0;
                  rsp_err  <= 1'b0;
               end else if (tmo_hit) begin
                  // the failed beat counts as spent; DRAIN only eats what is left
                  beats    <= beats - HBA_BEATS_WIDTH'(1);
                  rsp_data <= '0;
                  rsp_err  <= 1'b1;
               end
            ST_GAP:
               if (!hba_rnw && more_beats) hba_abus <= abus_inc;
            ST_RSP:
               if (rsp_acc && !rsp_err && hba_rnw && more_beats) hba_abus <= abus_inc;
            ST_DRAIN:
               if (wd_acc) beats <= beats - HBA_BEATS_WIDTH'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_hba_cmd_master.sv
// Directed table-driven bench for hba_cmd_master with a behavioural HBA slave,
// write-byte source and response sink running on the falling clock edge.
module tb_hba_cmd_master;

   logic        hba_clk = 1'b0;
   logic        hba_reset;
   logic        cmd_valid, cmd_ready, cmd_rnw;
   logic [11:0] cmd_addr;
   logic [3:0]  cmd_count;
   logic        wdata_valid, wdata_ready;
   logic [7:0]  wdata;
   logic        rsp_valid, rsp_ready;
   logic [7:0]  rsp_data;
   logic        rsp_err;
   logic        hba_select, hba_rnw;
   logic [11:0] hba_abus;
   logic [7:0]  hba_dbus;
   logic        hba_xferack;
   logic [7:0]  hba_dbus_slave;

   always #5 hba_clk = ~hba_clk;

   hba_cmd_master dut (
      .hba_clk        (hba_clk),
      .hba_reset      (hba_reset),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_rnw        (cmd_rnw),
      .cmd_addr       (cmd_addr),
      .cmd_count      (cmd_count),
      .wdata_valid    (wdata_valid),
      .wdata_ready    (wdata_ready),
      .wdata          (wdata),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_data       (rsp_data),
      .rsp_err        (rsp_err),
      .hba_select     (hba_select),
      .hba_rnw        (hba_rnw),
      .hba_abus       (hba_abus),
      .hba_dbus       (hba_dbus),
      .hba_xferack    (hba_xferack),
      .hba_dbus_slave (hba_dbus_slave)
   );

   typedef struct {
      logic        rnw;
      logic [11:0] addr;
      logic [3:0]  cnt;
      int          ack;       // select-high cycles before ack; -1 = never
      logic [7:0]  base;      // slave read data = base + beat index
      logic [7:0]  wb0;       // first write byte
      int          wstep;     // write byte increment
      int          nrsp;
      logic [7:0]  r0_data;
      logic        r0_err;
      logic [7:0]  rl_data;
      int          nxfer;
      logic [11:0] x0_addr, x1_addr, xl_addr;
      logic [7:0]  xl_dbus;
      int          sel_len;
      int          consumed;
   } vec_t;

   vec_t vt[8];

   int n_vec = 0;
   int n_bad = 0;

   // slave / source / sink state
   int          ack_dly = -1;
   logic [7:0]  slv_base = 8'h00;
   int          ack_idx = 0;
   int          sel_age = 0;
   logic [20:0] prev_bus = '0;
   logic [11:0] x_addr[$];
   logic [7:0]  x_dbus[$];
   int          x_len[$];
   logic [7:0]  rsp_d[$];
   logic        rsp_e[$];
   logic [7:0]  wd_mem[16];
   int          wd_n = 0, wd_idx = 0;
   logic        wd_take = 1'b0;
   logic        stall_arm = 1'b0, stall_start = 1'b0;
   int          stall_cnt = 0, sel_in_stall = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // HBA slave: ack after ack_dly select-high cycles, log each transfer on select fall
   initial begin
      hba_xferack = 1'b0;
      hba_dbus_slave = 8'h00;
      forever begin
         @(negedge hba_clk);
         hba_xferack = 1'b0;
         hba_dbus_slave = 8'h00;
         if (hba_select) begin
            if (sel_age > 0) chk("bus_stable", 32'({hba_abus, hba_rnw, hba_dbus}), 32'(prev_bus));
            prev_bus = {hba_abus, hba_rnw, hba_dbus};
            if (sel_age == ack_dly) begin
               hba_xferack = 1'b1;
               hba_dbus_slave = slv_base + 8'(ack_idx);
               ack_idx++;
            end
            sel_age++;
         end else if (sel_age > 0) begin
            x_addr.push_back(prev_bus[20:9]);
            x_dbus.push_back(prev_bus[7:0]);
            x_len.push_back(sel_age);
            sel_age = 0;
         end
      end
   end

   // write byte source
   initial begin
      wdata_valid = 1'b0;
      wdata = 8'h00;
      forever begin
         @(negedge hba_clk);
         if (wd_take) wd_idx++;
         wdata_valid = (wd_idx < wd_n);
         wdata = wdata_valid ? wd_mem[wd_idx & 15] : 8'h00;
         wd_take = wdata_valid && wdata_ready;
      end
   end

   // response sink with optional one-shot 10-cycle stall after the first response
   initial begin
      rsp_ready = 1'b1;
      forever begin
         @(negedge hba_clk);
         if (stall_start) begin
            rsp_ready = 1'b0;
            stall_cnt = 10;
            stall_start = 1'b0;
         end else if (stall_cnt > 0) begin
            stall_cnt--;
            if (stall_cnt == 0) rsp_ready = 1'b1;
         end
         if (stall_cnt > 0 && hba_select) sel_in_stall++;
         if (rsp_valid && rsp_ready) begin
            rsp_d.push_back(rsp_data);
            rsp_e.push_back(rsp_err);
            if (stall_arm) begin
               stall_arm = 1'b0;
               stall_start = 1'b1;
            end
         end
      end
   end

   task automatic issue_cmd(input logic rnw, input logic [11:0] addr, input logic [3:0] cnt);
      int t = 0;
      while (!cmd_ready && t < 200) begin
         @(negedge hba_clk);
         t++;
      end
      chk("cmd_ready_wait", 32'(t < 200), 32'd1);
      cmd_valid = 1'b1;
      cmd_rnw   = rnw;
      cmd_addr  = addr;
      cmd_count = cnt;
      @(negedge hba_clk);
      cmd_valid = 1'b0;
   endtask

   task automatic run_vec(input int i);
      vec_t v;
      int   t, mx;
      v = vt[i];
      ack_dly  = v.ack;
      slv_base = v.base;
      ack_idx  = 0;
      x_addr.delete(); x_dbus.delete(); x_len.delete();
      rsp_d.delete(); rsp_e.delete();
      for (int k = 0; k < 16; k++) wd_mem[k] = v.wb0 + 8'(k * v.wstep);
      wd_idx  = 0;
      wd_take = 1'b0;
      wd_n    = v.rnw ? 0 : int'(v.cnt) + 1;
      issue_cmd(v.rnw, v.addr, v.cnt);
      t = 0;
      while (!(rsp_d.size() >= v.nrsp && cmd_ready) && t < 3000) begin
         @(negedge hba_clk);
         t++;
      end
      chk($sformatf("v%0d_done", i), 32'(t < 3000), 32'd1);
      repeat (2) @(negedge hba_clk);
      chk($sformatf("v%0d_nrsp", i), 32'(rsp_d.size()), 32'(v.nrsp));
      if (rsp_d.size() > 0) begin
         chk($sformatf("v%0d_rsp0_data", i), 32'(rsp_d[0]), 32'(v.r0_data));
         chk($sformatf("v%0d_rsp0_err", i), 32'(rsp_e[0]), 32'(v.r0_err));
         chk($sformatf("v%0d_rspl_data", i), 32'(rsp_d[rsp_d.size()-1]), 32'(v.rl_data));
      end
      chk($sformatf("v%0d_nxfer", i), 32'(x_addr.size()), 32'(v.nxfer));
      if (x_addr.size() > 0) begin
         mx = 0;
         foreach (x_len[k]) if (x_len[k] > mx) mx = x_len[k];
         chk($sformatf("v%0d_x0_addr", i), 32'(x_addr[0]), 32'(v.x0_addr));
         chk($sformatf("v%0d_xl_addr", i), 32'(x_addr[x_addr.size()-1]), 32'(v.xl_addr));
         chk($sformatf("v%0d_sel_len", i), 32'(mx), 32'(v.sel_len));
         if (!v.rnw) chk($sformatf("v%0d_xl_dbus", i), 32'(x_dbus[x_dbus.size()-1]), 32'(v.xl_dbus));
      end
      if (x_addr.size() > 1) chk($sformatf("v%0d_x1_addr", i), 32'(x_addr[1]), 32'(v.x1_addr));
      chk($sformatf("v%0d_consumed", i), 32'(wd_idx), 32'(v.consumed));
   endtask

   initial begin
      //          rnw   addr     cnt  ack base   wb0   step nrsp r0    e0    rl     nx x0       x1       xl       xl_db sel cons
      vt[0] = '{1'b1, 12'h012, 4'd0,  2, 8'hA5, 8'h00, 0,  1, 8'hA5, 1'b0, 8'hA5,  1, 12'h012, 12'h000, 12'h012, 8'h00,  3, 0};
      vt[1] = '{1'b0, 12'h1FE, 4'd2,  0, 8'h00, 8'h11, 17, 1, 8'h00, 1'b0, 8'h00,  3, 12'h1FE, 12'h1FF, 12'h100, 8'h33,  1, 3};
      vt[2] = '{1'b1, 12'hF40, 4'd0, -1, 8'h00, 8'h00, 0,  1, 8'h00, 1'b1, 8'h00,  1, 12'hF40, 12'h000, 12'hF40, 8'h00, 64, 0};
      vt[3] = '{1'b1, 12'h3FF, 4'd1,  1, 8'h50, 8'h00, 0,  2, 8'h50, 1'b0, 8'h51,  2, 12'h3FF, 12'h300, 12'h300, 8'h00,  2, 0};
      vt[4] = '{1'b0, 12'h220, 4'd3, -1, 8'h00, 8'h9A, 1,  1, 8'h00, 1'b1, 8'h00,  1, 12'h220, 12'h000, 12'h220, 8'h9A, 64, 4};
      vt[5] = '{1'b1, 12'h5F8, 4'd15, 0, 8'h00, 8'h00, 0, 16, 8'h00, 1'b0, 8'h0F, 16, 12'h5F8, 12'h5F9, 12'h507, 8'h00,  1, 0};
      vt[6] = '{1'b0, 12'h0AB, 4'd0,  3, 8'h00, 8'hC3, 0,  1, 8'h00, 1'b0, 8'h00,  1, 12'h0AB, 12'h000, 12'h0AB, 8'hC3,  4, 1};
      vt[7] = '{1'b1, 12'h040, 4'd3,  0, 8'h70, 8'h00, 0,  4, 8'h70, 1'b0, 8'h73,  4, 12'h040, 12'h041, 12'h043, 8'h00,  1, 0};

      hba_reset = 1'b1;
      cmd_valid = 1'b0;
      cmd_rnw   = 1'b0;
      cmd_addr  = '0;
      cmd_count = '0;
      repeat (3) @(negedge hba_clk);
      chk("reset_ctl", 32'({cmd_ready, wdata_ready, rsp_valid, rsp_err, hba_select, hba_rnw}), 32'd0);
      chk("reset_bus", 32'({hba_abus, hba_dbus, rsp_data}), 32'd0);
      hba_reset = 1'b0;
      @(negedge hba_clk);
      chk("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);

      for (int i = 0; i < 7; i++) run_vec(i);

      // response backpressure: only the already-started beat may use the bus
      stall_arm = 1'b1;
      sel_in_stall = 0;
      run_vec(7);
      chk("stall_sel_cycles", 32'(sel_in_stall), 32'd1);
      for (int k = 0; k < 4; k++)
         if (k < rsp_d.size()) chk($sformatf("stall_order%0d", k), 32'(rsp_d[k]), 32'(8'h70 + 8'(k)));

      // reset while select is high
      ack_dly = -1;
      issue_cmd(1'b1, 12'h011, 4'd0);
      begin
         int t = 0;
         while (!hba_select && t < 50) begin
            @(negedge hba_clk);
            t++;
         end
         chk("midrst_select_seen", 32'(hba_select), 32'd1);
      end
      repeat (4) @(negedge hba_clk);
      hba_reset = 1'b1;
      @(negedge hba_clk);
      chk("midrst_ctl", 32'({hba_select, rsp_valid, wdata_ready, cmd_ready}), 32'd0);
      hba_reset = 1'b0;
      @(negedge hba_clk);
      chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
      run_vec(0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

endmodule
